// File: rtl/shifter_edge_n.sv
// ---------------------------------------------------------------------------
// shifter_edge_n
//   Multi-channel shift/delay line with per-channel edge detection.
//   Every Data_in bit runs through its own DEPTH-stage register chain.
//   Edges seen at the head of each chain are reported as one-cycle pulses,
//   latched sticky flags and a saturating count of cycles with any edge.
//
//   Optional glitch filter: define SHIFTER_EDGE_N_GLITCH_FILTER_EN. The edge
//   detector then watches a filtered copy of stage 0 that only follows the
//   input after FILTER_LEN consecutive differing samples. data_delayed is
//   never filtered.
//
// Ports
//   clock        in   rising-edge clock
//   reset        in   asynchronous active-high reset
//   Data_in      in   [WIDTH]  raw channel inputs
//   mode         in   [2]      edge select: 00 none, 01 rise, 10 fall, 11 both
//   clear        in   synchronous clear of edge_sticky / edge_count
//   data_delayed out  [WIDTH]  last stage of each chain
//   edge_pulse   out  [WIDTH]  registered one-cycle edge events
//   edge_sticky  out  [WIDTH]  latched edge flags
//   edge_count   out  [CNT_W]  saturating count of pulse cycles
// ---------------------------------------------------------------------------
module shifter_edge_n #(
  parameter int WIDTH      = 4,
  parameter int DEPTH      = 4,
  parameter int CNT_W      = 8,
  parameter int FILTER_LEN = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] Data_in,
  input  logic [1:0]       mode,
  input  logic             clear,
  output logic [WIDTH-1:0] data_delayed,
  output logic [WIDTH-1:0] edge_pulse,
  output logic [WIDTH-1:0] edge_sticky,
  output logic [CNT_W-1:0] edge_count
);

  if (WIDTH < 1 || DEPTH < 2 || CNT_W < 1 || FILTER_LEN < 1) begin : g_param_check
    $error("shifter_edge_n: illegal parameter value");
  end

  typedef enum logic [1:0] {
    MODE_NONE = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } mode_e;

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];
  logic [WIDTH-1:0] pulse_q, pulse_d;
  logic [WIDTH-1:0] sticky_q, sticky_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [WIDTH-1:0] cur, prev, rise, fall;
  logic             any_edge;

  // Shift chains
  always_comb begin
    stage_d[0] = Data_in;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      stage_d[k] = stage_q[k-1];
    end
  end

`ifdef SHIFTER_EDGE_N_GLITCH_FILTER_EN
  // Stability counter only needs to reach FILTER_LEN-1; the next differing
  // sample flips the filtered bit.
  localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [WIDTH-1:0] filt_q, filt_d, filt_prev_q;
  logic [FCW-1:0]   fcnt_q [WIDTH];
  logic [FCW-1:0]   fcnt_d [WIDTH];

  always_comb begin
    filt_d = filt_q;
    for (int unsigned c = 0; c < WIDTH; c++) begin
      fcnt_d[c] = '0;
      if (stage_q[0][c] != filt_q[c]) begin
        if (fcnt_q[c] == FCW'(FILTER_LEN - 1)) begin
          filt_d[c] = stage_q[0][c];
        end else begin
          fcnt_d[c] = fcnt_q[c] + FCW'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      filt_q      <= '0;
      filt_prev_q <= '0;
      for (int unsigned c = 0; c < WIDTH; c++) begin
        fcnt_q[c] <= '0;
      end
    end else begin
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      for (int unsigned c = 0; c < WIDTH; c++) begin
        fcnt_q[c] <= fcnt_d[c];
      end
    end
  end

  assign cur  = filt_q;
  assign prev = filt_prev_q;
`else
  assign cur  = stage_q[0];
  assign prev = stage_q[1];
`endif

  // Edge evaluation, sticky flags and counter
  always_comb begin
    rise = cur & ~prev;
    fall = ~cur & prev;

    pulse_d = '0;
    case (mode_e'(mode))
      MODE_NONE: pulse_d = '0;
      MODE_RISE: pulse_d = rise;
      MODE_FALL: pulse_d = fall;
      MODE_BOTH: pulse_d = rise | fall;
      default:   pulse_d = '0;
    endcase

    any_edge = |pulse_d;

    // A pulse in the same cycle as clear survives the clear.
    sticky_d = (clear ? '0 : sticky_q) | pulse_d;

    count_d = count_q;
    if (clear) begin
      count_d = any_edge ? CNT_W'(1) : '0;
    end else if (any_edge && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        stage_q[k] <= '0;
      end
      pulse_q  <= '0;
      sticky_q <= '0;
      count_q  <= '0;
    end else begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        stage_q[k] <= stage_d[k];
      end
      pulse_q  <= pulse_d;
      sticky_q <= sticky_d;
      count_q  <= count_d;
    end
  end

  assign data_delayed = stage_q[DEPTH-1];
  assign edge_pulse   = pulse_q;
  assign edge_sticky  = sticky_q;
  assign edge_count   = count_q;

endmodule

// File: tb/tb_shifter_edge_n.sv
// ---------------------------------------------------------------------------
// tb_shifter_edge_n
//   Self-checking bench for shifter_edge_n (WIDTH=4, DEPTH=4, CNT_W=8,
//   FILTER_LEN=3). A behavioural model pushes the expected outputs for each
//   clock into a queue as stimulus is applied; each test pops and compares
//   once the DUT has clocked. Fixed-timing checks taken directly from the
//   intended behaviour complement the model.
// ---------------------------------------------------------------------------
module tb_shifter_edge_n;

  localparam int W  = 4;
  localparam int D  = 4;
  localparam int CW = 8;
  localparam int FL = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic [W-1:0]  data_in;
  logic [1:0]    mode;
  logic          clear;
  logic [W-1:0]  data_delayed;
  logic [W-1:0]  edge_pulse;
  logic [W-1:0]  edge_sticky;
  logic [CW-1:0] edge_count;

  shifter_edge_n #(
    .WIDTH      (W),
    .DEPTH      (D),
    .CNT_W      (CW),
    .FILTER_LEN (FL)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .Data_in      (data_in),
    .mode         (mode),
    .clear        (clear),
    .data_delayed (data_delayed),
    .edge_pulse   (edge_pulse),
    .edge_sticky  (edge_sticky),
    .edge_count   (edge_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [W-1:0]  dly;
    logic [W-1:0]  pulse;
    logic [W-1:0]  sticky;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t obs;
  exp_t e;

  int tests = 0;
  int fails = 0;

  // Behavioural model state
  logic [W-1:0]  m_stage [D];
  logic [W-1:0]  m_pulse;
  logic [W-1:0]  m_sticky;
  logic [CW-1:0] m_cnt;
  logic [W-1:0]  m_f;
  logic [W-1:0]  m_fprev;
  int            m_fcnt [W];

  task automatic model_reset();
    for (int k = 0; k < D; k++) m_stage[k] = '0;
    m_pulse  = '0;
    m_sticky = '0;
    m_cnt    = '0;
    m_f      = '0;
    m_fprev  = '0;
    for (int c = 0; c < W; c++) m_fcnt[c] = 0;
  endtask

  // Drive one clock of stimulus, push the model's expectation, sample DUT.
  task automatic step(input logic [W-1:0] d, input logic [1:0] md, input logic clr);
    logic [W-1:0] cur, prev, rise, fall, p, s0;
    @(negedge clock);
    data_in = d;
    mode    = md;
    clear   = clr;
`ifdef SHIFTER_EDGE_N_GLITCH_FILTER_EN
    cur  = m_f;
    prev = m_fprev;
`else
    cur  = m_stage[0];
    prev = m_stage[1];
`endif
    rise = cur & ~prev;
    fall = ~cur & prev;
    case (md)
      2'b00:   p = '0;
      2'b01:   p = rise;
      2'b10:   p = fall;
      default: p = rise | fall;
    endcase
    m_sticky = clr ? p : (m_sticky | p);
    if (clr) m_cnt = (p != 0) ? CW'(1) : CW'(0);
    else if (p != 0 && m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
    m_pulse = p;
    s0 = m_stage[0];
    m_fprev = m_f;
    for (int c = 0; c < W; c++) begin
      if (s0[c] == m_f[c]) m_fcnt[c] = 0;
      else if (m_fcnt[c] == FL - 1) begin
        m_f[c] = s0[c];
        m_fcnt[c] = 0;
      end else m_fcnt[c] = m_fcnt[c] + 1;
    end
    for (int k = D - 1; k > 0; k--) m_stage[k] = m_stage[k-1];
    m_stage[0] = d;
    exp_q.push_back(exp_t'{m_stage[D-1], m_pulse, m_sticky, m_cnt});
    @(posedge clock);
    #1;
    obs = {data_delayed, edge_pulse, edge_sticky, edge_count};
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if ({data_delayed, edge_pulse, edge_sticky, edge_count} !== '0) begin
      fails++;
      $display("FAIL reset_initial: got dly=%b pulse=%b sticky=%b cnt=%0d, expected all zero",
               data_delayed, edge_pulse, edge_sticky, edge_count);
    end
    @(posedge clock);
    @(posedge clock);
    #2;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      step(4'b0000, 2'b00, 1'b0);
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL idle_step%0d: got %h expected %h", i, obs, e);
      end
    end
    tests++;
    if ({data_delayed, edge_pulse, edge_sticky, edge_count} !== '0) begin
      fails++;
      $display("FAIL idle_final: got dly=%b pulse=%b sticky=%b cnt=%0d, expected all zero",
               data_delayed, edge_pulse, edge_sticky, edge_count);
    end
  endtask

  task automatic test_rise();
    for (int i = 0; i < 6; i++) begin
      step(4'b0001, 2'b01, 1'b0);
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL rise_step%0d: got %h expected %h", i, obs, e);
      end
`ifndef SHIFTER_EDGE_N_GLITCH_FILTER_EN
      if (i == 1) begin
        tests++;
        if (edge_pulse !== 4'b0001) begin
          fails++;
          $display("FAIL rise_pulse_timing: got %b expected 0001", edge_pulse);
        end
      end
`endif
      if (i == 2 || i == 3) begin
        tests++;
        if (data_delayed[0] !== (i == 3)) begin
          fails++;
          $display("FAIL rise_delay_step%0d: got %b expected %0d", i, data_delayed[0], i == 3);
        end
      end
    end
    tests++;
    if (edge_sticky !== 4'b0001 || edge_count !== 8'd1) begin
      fails++;
      $display("FAIL rise_sticky_count: got sticky=%b cnt=%0d expected 0001 and 1",
               edge_sticky, edge_count);
    end
  endtask

  task automatic test_fall_both();
    logic [5:0] fseq;
    logic [7:0] bseq;
    int npulse;
    logic [CW-1:0] cnt0;
    fseq = 6'b000101;   // bit i = sample i: 1,0,1,0,0,0
    bseq = 8'b00010101; // 1,0,1,0,1,0,0,0
    npulse = 0;
    cnt0 = edge_count;
    for (int i = 0; i < 6; i++) begin
      step({1'b0, fseq[i], 2'b01}, 2'b10, 1'b0);
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL fall_step%0d: got %h expected %h", i, obs, e);
      end
      if (edge_pulse != 0) npulse++;
    end
`ifndef SHIFTER_EDGE_N_GLITCH_FILTER_EN
    tests++;
    if (npulse != 2 || edge_count !== cnt0 + 8'd2) begin
      fails++;
      $display("FAIL fall_pulses: got %0d pulses cnt=%0d expected 2 pulses cnt=%0d",
               npulse, edge_count, cnt0 + 8'd2);
    end
`endif
    npulse = 0;
    cnt0 = edge_count;
    for (int i = 0; i < 8; i++) begin
      step({1'b0, bseq[i], 2'b01}, 2'b11, 1'b0);
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL both_step%0d: got %h expected %h", i, obs, e);
      end
      if (edge_pulse != 0) npulse++;
    end
`ifndef SHIFTER_EDGE_N_GLITCH_FILTER_EN
    tests++;
    if (npulse != 6 || edge_count !== cnt0 + 8'd6) begin
      fails++;
      $display("FAIL both_pulses: got %0d pulses cnt=%0d expected 6 pulses cnt=%0d",
               npulse, edge_count, cnt0 + 8'd6);
    end
`endif
  endtask

  task automatic test_saturation();
    logic t;
    for (int i = 0; i < 300; i++) begin
      t = (i % 2 == 0);
      step({2'b00, t, 1'b1}, 2'b11, 1'b0);
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL sat_step%0d: got %h expected %h", i, obs, e);
      end
    end
    tests++;
    if (edge_count !== 8'd255) begin
      fails++;
      $display("FAIL sat_limit: got cnt=%0d expected 255", edge_count);
    end
    step(4'b0011, 2'b11, 1'b1);
    e = exp_q.pop_front();
    tests++;
    if (obs !== e || edge_count !== 8'd1 || edge_sticky !== 4'b0010) begin
      fails++;
      $display("FAIL clear_with_pulse: got cnt=%0d sticky=%b expected cnt=1 sticky=0010",
               edge_count, edge_sticky);
    end
    for (int i = 0; i < 3; i++) begin
      step(4'b0011, 2'b11, 1'b0);
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL settle_step%0d: got %h expected %h", i, obs, e);
      end
    end
    step(4'b0011, 2'b11, 1'b1);
    e = exp_q.pop_front();
    tests++;
    if (obs !== e || edge_count !== 8'd0 || edge_sticky !== 4'b0000) begin
      fails++;
      $display("FAIL clear_quiet: got cnt=%0d sticky=%b expected cnt=0 sticky=0000",
               edge_count, edge_sticky);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) begin
      step({(i % 2 == 0), 3'b001}, 2'b11, 1'b0);
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL pre_reset_step%0d: got %h expected %h", i, obs, e);
      end
    end
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if ({data_delayed, edge_pulse, edge_sticky, edge_count} !== '0) begin
      fails++;
      $display("FAIL async_reset: got dly=%b pulse=%b sticky=%b cnt=%0d, expected all zero",
               data_delayed, edge_pulse, edge_sticky, edge_count);
    end
    data_in = 4'b0001;
    mode    = 2'b01;
    @(posedge clock);
    @(posedge clock);
    #2;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 7; i++) begin
      step(4'b0001, 2'b01, 1'b0);
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL post_reset_step%0d: got %h expected %h", i, obs, e);
      end
`ifndef SHIFTER_EDGE_N_GLITCH_FILTER_EN
      if (i == 1) begin
        tests++;
        if (edge_pulse !== 4'b0001) begin
          fails++;
          $display("FAIL held_through_reset: got %b expected 0001", edge_pulse);
        end
      end
`endif
    end
  endtask

`ifdef SHIFTER_EDGE_N_GLITCH_FILTER_EN
  task automatic test_filter();
    int n2, n3;
    n2 = 0;
    n3 = 0;
    for (int i = 0; i < 12; i++) begin
      step({(i == 2 || i == 3), 3'b001}, 2'b01, 1'b0);
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL glitch2_step%0d: got %h expected %h", i, obs, e);
      end
      if (edge_pulse[3]) n2++;
    end
    tests++;
    if (n2 != 0) begin
      fails++;
      $display("FAIL glitch2_pulses: got %0d expected 0", n2);
    end
    for (int i = 0; i < 12; i++) begin
      step({(i < 3), 3'b001}, 2'b01, 1'b0);
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL glitch3_step%0d: got %h expected %h", i, obs, e);
      end
      if (edge_pulse[3]) n3++;
    end
    tests++;
    if (n3 != 1) begin
      fails++;
      $display("FAIL glitch3_pulses: got %0d expected 1", n3);
    end
  endtask
`endif

  initial begin
    reset   = 1'b1;
    data_in = '0;
    mode    = 2'b00;
    clear   = 1'b0;
    model_reset();
    test_reset();
    test_rise();
    test_fall_both();
`ifndef SHIFTER_EDGE_N_GLITCH_FILTER_EN
    test_saturation();
`endif
    test_async_reset();
`ifdef SHIFTER_EDGE_N_GLITCH_FILTER_EN
    test_filter();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
